// File: rtl/avalon_pio_bidir.sv
// avalon_pio_bidir: Avalon-MM parallel I/O slave with per-bit direction,
// synchronised inputs, edge capture with maskable level interrupt.
// Latency: writes take effect on the strobe edge; reads are registered (1 cycle); no wait states.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   address, chipselect,  Avalon-MM slave bus (word addressed, write_n active low)
//   write_n, writedata,
//   readdata
//   in_port               asynchronous external inputs (synchronised internally)
//   out_port, oe_port     output data register and per-bit output enable
//   irq                   level interrupt, |(edge_capture & irq_mask)
//
// Build option: define PIO_SET_CLEAR_EN to implement OUTSET (addr 4) and
// OUTCLEAR (addr 5); otherwise those addresses behave as reserved.
module avalon_pio_bidir #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0,
    parameter int                    EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_MASK = 3'd2;
    localparam logic [2:0] A_EDGE = 3'd3;
`ifdef PIO_SET_CLEAR_EN
    localparam logic [2:0] A_SET  = 3'd4;
    localparam logic [2:0] A_CLR  = 3'd5;
`endif

    logic [DATA_WIDTH-1:0] out_q,  out_d;
    logic [DATA_WIDTH-1:0] dir_q,  dir_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q,  cap_d;
    logic [DATA_WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [31:0]           readdata_q, readdata_d;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdat;
    logic [DATA_WIDTH-1:0] cap_clr;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_wdata;

    assign wr_en = chipselect & ~write_n;
    assign wdat  = writedata[DATA_WIDTH-1:0];
    // Bits above DATA_WIDTH are intentionally ignored.
    assign unused_wdata = ^writedata;

    // Edge detect works on the synchronised sample (s2) against its history
    // (s3), so nothing here ever sees raw in_port.
    always_comb begin
        case (EDGE_TYPE)
            1:       edge_det = ~s2_q & s3_q;
            2:       edge_det = s2_q ^ s3_q;
            default: edge_det = s2_q & ~s3_q;
        endcase
    end

    // Register write decode.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en) begin
            case (address)
                A_DATA:  out_d   = wdat;
                A_DIR:   dir_d   = wdat;
                A_MASK:  mask_d  = wdat;
                A_EDGE:  cap_clr = wdat;
`ifdef PIO_SET_CLEAR_EN
                A_SET:   out_d   = out_q | wdat;
                A_CLR:   out_d   = out_q & ~wdat;
`endif
                default: ;
            endcase
        end
        // A new edge in the same cycle as a clear of that bit keeps the bit
        // set, so no event is ever lost to a racing acknowledge.
        cap_d = (cap_q & ~cap_clr) | edge_det;
    end

    // Read mux; captured into readdata_q only when selected.
    always_comb begin
        rd_val = '0;
        case (address)
            A_DATA:  rd_val = (dir_q & out_q) | (~dir_q & s2_q);
            A_DIR:   rd_val = dir_q;
            A_MASK:  rd_val = mask_q;
            A_EDGE:  rd_val = cap_q;
            default: rd_val = '0;
        endcase
        readdata_d = readdata_q;
        if (chipselect) begin
            readdata_d                   = '0;
            readdata_d[DATA_WIDTH-1:0]   = rd_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= RESET_VALUE;
            dir_q      <= DIR_RESET;
            mask_q     <= '0;
            cap_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            readdata_q <= '0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            s1_q       <= in_port;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = out_q;
    assign oe_port  = dir_q;
    assign readdata = readdata_q;
    // Purely from flops: no combinational path from in_port to irq.
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_bidir.sv
module tb_avalon_pio_bidir;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd2;
    logic [7:0]  out0, out2, oe0, oe2;
    logic        irq0, irq2;

    int total = 0;
    int bad   = 0;

`ifdef PIO_SET_CLEAR_EN
    localparam logic [7:0] EXP_SET = 8'hFF;
    localparam logic [7:0] EXP_CLR = 8'h7E;
`else
    localparam logic [7:0] EXP_SET = 8'h0F;
    localparam logic [7:0] EXP_CLR = 8'h0F;
`endif

    always #5 clk = ~clk;

    avalon_pio_bidir #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hF0), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
        .out_port(out0), .oe_port(oe0), .irq(irq0));

    avalon_pio_bidir #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hF0), .EDGE_TYPE(2)) u2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
        .out_port(out2), .oe_port(oe2), .irq(irq2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e2, input string tag);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        chk({tag, "_u0"}, rd0, e0);
        chk({tag, "_u2"}, rd2, e2);
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 8'h3C;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_out", {24'h0, out0}, 32'hA5);
        chk("rst_oe", {24'h0, oe0}, 32'hF0);
        chk("rst_irq", {31'h0, irq0}, 32'h0);
        chk("rst_rd", rd0, 32'h0);
        rd(3'd3, 32'h0, 32'h0, "cap_early");

        // Input held high across reset release shows up as rising edges
        repeat (3) @(negedge clk);
        rd(3'd0, 32'hAC, 32'hAC, "data_mixed");
        rd(3'd3, 32'h3C, 32'h3C, "cap_release");
        wr(3'd3, 32'hFF);
        rd(3'd3, 32'h0, 32'h0, "cap_w1c");

        // Output write and readback
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'hFFFF_FF12);
        chk("out_12", {24'h0, out0}, 32'h12);
        rd(3'd0, 32'h12, 32'h12, "data_12");
        @(negedge clk);
        chk("rd_hold", rd0, 32'h12);
        rd(3'd1, 32'hFF, 32'hFF, "dir_ff");

        // Set / clear (or reserved when not built in)
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'hF0);
        chk("outset", {24'h0, out0}, {24'h0, EXP_SET});
        wr(3'd5, 32'h81);
        chk("outclr", {24'h0, out0}, {24'h0, EXP_CLR});
        rd(3'd4, 32'h0, 32'h0, "rd_a4");
        rd(3'd5, 32'h0, 32'h0, "rd_a5");

        // Reserved addresses and unselected write
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'h00);
        chk("rsv_out", {24'h0, out0}, {24'h0, EXP_CLR});
        chk("rsv_oe", {24'h0, oe0}, 32'hFF);
        rd(3'd6, 32'h0, 32'h0, "rd_a6");
        rd(3'd7, 32'h0, 32'h0, "rd_a7");
        @(negedge clk);
        address = 3'd0; writedata = 32'h55; chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        chk("cs_low_out", {24'h0, out0}, {24'h0, EXP_CLR});
        rd(3'd0, {24'h0, EXP_CLR}, {24'h0, EXP_CLR}, "data_after");

        // Rising edge on bit 2 with mask 04: irq timing
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h04);
        rd(3'd2, 32'h04, 32'h04, "mask_04");
        rd(3'd3, 32'h0, 32'h0, "cap_clean");
        chk("irq_idle", {31'h0, irq0}, 32'h0);
        in_port = 8'h04;
        @(negedge clk);
        chk("irq_n", {31'h0, irq0}, 32'h0);
        @(negedge clk);
        chk("irq_n1", {31'h0, irq0}, 32'h0);
        @(negedge clk);
        chk("irq_n2_u0", {31'h0, irq0}, 32'h1);
        chk("irq_n2_u2", {31'h0, irq2}, 32'h1);
        rd(3'd3, 32'h04, 32'h04, "cap_04");
        wr(3'd3, 32'h04);
        chk("irq_clr_u0", {31'h0, irq0}, 32'h0);
        chk("irq_clr_u2", {31'h0, irq2}, 32'h0);
        rd(3'd3, 32'h0, 32'h0, "cap_cleared");

        // Edge on bit 1 coincides with write-1-clear of bit 1
        in_port = 8'h06;
        @(negedge clk);
        @(negedge clk);
        address = 3'd3; writedata = 32'h02; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        rd(3'd3, 32'h02, 32'h02, "set_wins");
        wr(3'd3, 32'h02);
        rd(3'd3, 32'h0, 32'h0, "cap_b1_clr");

        // Any-edge mode on bit 7, masked then unmasked
        wr(3'd2, 32'h00);
        in_port = 8'h86;
        repeat (4) @(negedge clk);
        chk("irq_masked", {31'h0, irq2}, 32'h0);
        rd(3'd3, 32'h80, 32'h80, "cap_b7_rise");
        wr(3'd3, 32'hFF);
        in_port = 8'h06;
        repeat (4) @(negedge clk);
        chk("irq_masked_fall", {31'h0, irq2}, 32'h0);
        rd(3'd3, 32'h00, 32'h80, "cap_b7_fall");
        wr(3'd2, 32'h80);
        chk("irq_unmask_u2", {31'h0, irq2}, 32'h1);
        chk("irq_unmask_u0", {31'h0, irq0}, 32'h0);

        // Reset mid-operation
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_out", {24'h0, out2}, 32'hA5);
        chk("mid_rst_oe", {24'h0, oe2}, 32'hF0);
        chk("mid_rst_irq", {31'h0, irq2}, 32'h0);
        chk("mid_rst_rd", rd2, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd(3'd2, 32'h0, 32'h0, "mid_rst_mask");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_pio_bidir.md
# avalon_pio_bidir

Parametrised Avalon-MM parallel I/O slave. Successor to the fixed 4-bit output-only PIO: configurable width, per-bit direction, synchronised input sampling, edge capture with maskable interrupt, and optional atomic bit set/clear of the output register. Sits on the Nios II data master interconnect as a memory-mapped peripheral driving board LEDs, buttons and GPIO headers.

## Interface

Parameters:
- DATA_WIDTH, 8, number of I/O bits (1..32)
- RESET_VALUE, 0, reset value of the output data register (DATA_WIDTH bits)
- DIR_RESET, 0, reset value of the direction register (1 = output)
- EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  3  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits above DATA_WIDTH ignored
- readdata  out  32  registered read data; bits above DATA_WIDTH read 0
- in_port  in  DATA_WIDTH  asynchronous external inputs
- out_port  out  DATA_WIDTH  output data register
- oe_port  out  DATA_WIDTH  direction register (output enable per bit)
- irq  out  1  level interrupt request, active-high

## Operation

Register map (word addresses):
- 0 DATA: write sets output register; read returns per bit `dir ? out_reg : in_sync`
- 1 DIRECTION: R/W, 1 = bit is output
- 2 IRQ_MASK: R/W, reset 0
- 3 EDGE_CAPTURE: read returns capture bits; write-1-to-clear per bit
- 4 OUTSET: write ORs writedata into output register; reads 0
- 5 OUTCLEAR: write clears output bits where writedata = 1; reads 0
- 6, 7: reserved; writes ignored, reads 0

Behaviour:
- in_port passes a two-flop synchroniser (s1, s2) then a history flop s3; edge = s2 & ~s3 (rising), ~s2 & s3 (falling), s2 ^ s3 (any).
- Edge capture runs on all bits regardless of direction.
- Capture bit sets on edge; clears on write-1 to address 3. Edge and clear of the same bit in the same cycle: set wins.
- irq = |(edge_capture & irq_mask), combinational from registers, no glitch path from in_port.
- Write with address outside map or chipselect low: no state change.
- Reset values: out_port = RESET_VALUE, oe_port = DIR_RESET, irq_mask = 0, edge_capture = 0, s1/s2/s3 = 0, readdata = 0, irq = 0.
- Reset mid-operation: all state returns to reset values immediately; synchroniser history cleared, so an input held high at reset release produces a rising edge capture 3 cycles later (documented, intended).

## Timing

- Write: register updates at the rising clk edge where chipselect & ~write_n; out_port/oe_port change the same edge.
- Read: readLatency 1; readdata registered on the edge where chipselect is high, holds value otherwise.
- in_port change before edge N: s2 reflects it after edge N+1; capture bit and irq assert after edge N+2.
- DATA read of an input bit reflects in_port after 2 cycles of synchronisation plus read latency.
- Back-to-back writes supported every cycle; no wait states.

## Configuration

- Macro PIO_SET_CLEAR_EN.
- Defined: addresses 4 and 5 implement OUTSET/OUTCLEAR as above.
- Undefined: addresses 4 and 5 behave as reserved (writes ignored, read 0); set/clear logic not synthesised.

## Test plan

- Reset, DATA_WIDTH=8, RESET_VALUE=8'hA5, DIR_RESET=8'hF0 -> out_port=A5, oe_port=F0, irq=0, read addr 0 with in_port=8'h3C returns 8'hAC after synchroniser settles.
- Write DATA=32'hFFFF_FF12 -> out_port=8'h12; read addr 0 with DIR=FF returns 32'h0000_0012 one cycle after read.
- With macro: DATA=8'h0F, OUTSET 8'hF0 -> FF, OUTCLEAR 8'h81 -> 7E; without macro same writes leave 0F and reads of 4/5 return 0.
- EDGE_TYPE=0, mask=8'h04, in_port[2] 0->1 -> capture=8'h04 and irq=1 two edges after sampling edge; write 8'h04 to addr 3 -> capture=0, irq=0 next cycle.
- Rising edge on bit 1 in same cycle as write-1-clear of bit 1 -> capture bit 1 remains 1.
- EDGE_TYPE=2, mask=0, toggle in_port[7] -> capture[7]=1, irq stays 0; set mask=8'h80 -> irq=1 the cycle after the write.
